// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sharing of one combinational ALU between two requesters
module alu_share_arbiter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [3:0]      req0_ctrl,
  input  logic [XLEN-1:0] req0_a,
  input  logic [XLEN-1:0] req0_b,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [3:0]      req1_ctrl,
  input  logic [XLEN-1:0] req1_a,
  input  logic [XLEN-1:0] req1_b,
  output logic            rsp0_valid,
  input  logic            rsp0_ready,
  output logic [XLEN-1:0] rsp0_result,
  output logic            rsp0_zero,
  output logic            rsp0_err,
  output logic            rsp1_valid,
  input  logic            rsp1_ready,
  output logic [XLEN-1:0] rsp1_result,
  output logic            rsp1_zero,
  output logic            rsp1_err,
  output logic            alu_issue,
  output logic [3:0]      alu_ctrl,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  input  logic [XLEN-1:0] alu_result,
  input  logic            alu_zero
);
  logic [1:0] req_valid, rsp_ready, inflight, rsp_valid, rsp_zero, rsp_err, elig, grant;
  logic [XLEN-1:0] rsp_result [2];
  logic [XLEN-1:0] a, b;
  logic [3:0] ctrl;
  logic prio, tag, sel, legal, issue;
  assign req_valid = {req1_valid, req0_valid};
  assign rsp_ready = {rsp1_ready, rsp0_ready};
  assign elig = reset ? 2'b00 : req_valid & ~inflight & (~rsp_valid | rsp_ready);
  assign grant = {elig[1] & (~elig[0] | prio), elig[0] & (~elig[1] | ~prio)};
  assign sel = grant[1];
  assign ctrl = sel ? req1_ctrl : req0_ctrl;
  assign a = sel ? req1_a : req0_a;
  assign b = sel ? req1_b : req0_b;
  assign legal = ctrl != 4'b1011 && !(ctrl[3:2] == 2'b11 && ctrl[1:0] != 2'b00);
  assign issue = |grant && legal;
  assign req0_ready = grant[0];
  assign req1_ready = grant[1];
  assign rsp0_valid = rsp_valid[0];
  assign rsp1_valid = rsp_valid[1];
  assign rsp0_result = rsp_result[0];
  assign rsp1_result = rsp_result[1];
  assign rsp0_zero = rsp_zero[0];
  assign rsp1_zero = rsp_zero[1];
  assign rsp0_err = rsp_err[0];
  assign rsp1_err = rsp_err[1];
  always_ff @(posedge clk) begin
    if (reset) begin
      prio <= 1'b0;
      tag <= 1'b0;
      alu_issue <= 1'b0;
      alu_ctrl <= '0;
      alu_a <= '0;
      alu_b <= '0;
      inflight <= '0;
      rsp_valid <= '0;
      rsp_zero <= '0;
      rsp_err <= '0;
      for (int n = 0; n < 2; n++) rsp_result[n] <= '0;
    end else begin
      prio <= |grant ? ~sel : prio;
      tag <= sel;
      alu_issue <= issue;
      alu_ctrl <= issue ? ctrl : '0;
      alu_a <= issue ? a : '0;
      alu_b <= issue ? b : '0;
      for (int n = 0; n < 2; n++) begin
        if (alu_issue && tag == 1'(n)) begin
          rsp_result[n] <= alu_result;
          rsp_zero[n] <= alu_zero;
          rsp_err[n] <= 1'b0;
          rsp_valid[n] <= 1'b1;
          inflight[n] <= 1'b0;
        end else if (grant[n]) begin
          inflight[n] <= legal;
          rsp_valid[n] <= !legal;
          if (!legal) begin
            rsp_result[n] <= '0;
            rsp_zero[n] <= 1'b0;
            rsp_err[n] <= 1'b1;
          end
        end else if (rsp_ready[n]) begin
          rsp_valid[n] <= 1'b0;
        end
      end
    end
  end
endmodule
